datamem_arbiter: RTL and testbench
==================================

# datamem_arbiter

Two-port arbiter sharing the single-ported data memory (`datamem`, 16-bit words, 14-bit address, one access per cycle, synchronous read) between the CPU load/store unit (requester 0) and the DMA/debug loader (requester 1). Each cycle it grants at most one request using round-robin arbitration and drives the memory's `di`/`ad`/`we`. It tags each granted read and returns the memory's `dout` only to the requester that issued it, with a per-requester hold register so read data stays stable.

## Interface
- `WIDTH`, 16, data word width; matches `datamem` width.
- `AW`, 14, address width.
- `clk`  in  1  single clock; all flops rise-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rqN_valid`  in  1  requester N (N = 0, 1) has an access pending.
- `rqN_we`  in  1  1 = write, 0 = read.
- `rqN_ad`  in  AW  word address.
- `rqN_di`  in  WIDTH  write data.
- `rqN_ready`  out  1  grant; the access transfers in a cycle with `rqN_valid && rqN_ready`.
- `rqN_rvalid`  out  1  one-cycle pulse: read data for requester N is on `rqN_rdata`.
- `rqN_rdata`  out  WIDTH  read data; holds the last value returned to N.
- `mem_we`, `mem_ad`, `mem_di`  out  1/AW/WIDTH  to the `datamem` `we`, `ad`, `di` ports.
- `mem_dout`  in  WIDTH  from the `datamem` `dout` port.

## Operation
- Round-robin pointer `last_gnt` (1 bit) records the most recent winner.
- Only one requester valid: that requester is granted, every cycle (back-to-back).
- Both requesters valid: grant `!last_gnt`. `last_gnt` updates only on a cycle with a grant.
- `rqN_ready` is combinational from `rqN_valid`, the other requester's valid, and `last_gnt`. It never depends on `rvalid`.
- A requester holds `valid`, `we`, `ad` and `di` stable until it is granted. Dropping `valid` before the grant is legal (the request is withdrawn).
- Granted cycle: `mem_ad`/`mem_di` = winner's fields and `mem_we` = winner's `we`.
- No grant: `mem_we` = 0, `mem_ad` = 0, `mem_di` = 0. The memory's `dout` is not captured.
- Granted read: set the read-pending flop and record the owner id.
  - Next cycle: assert the owner's `rvalid`. The owner's `rdata` equals `mem_dout` combinationally.
  - The owner's hold register captures `mem_dout` at that cycle's end.
- The non-owner's `rdata` keeps its hold value.
- A granted write produces no `rvalid`. `mem_dout` is ignored, because `datamem` does not update `dout` on writes.

## Timing
- Reset values:
  - `last_gnt` = 1, so requester 0 wins the first contention.
  - Read-pending = 0, both `rvalid` = 0, both `rdata` = 0.
  - `mem_we` = 0.
- Grant latency: 0 cycles. `ready` is asserted in the same cycle as `valid`, subject to arbitration.
- Read latency: grant in cycle T gives `rvalid` in T+1. Pipelined: reads granted in T and T+1 return in T+1 and T+2.
- Write then read of the same address in consecutive cycles returns the new data.
- Under sustained contention each requester receives exactly every other grant. Maximum wait is 1 cycle.
- Reset asserted mid-operation: the pending read is dropped, with no `rvalid` after reset release. `last_gnt` returns to 1.
- A requester may issue a new request in the same cycle its `rvalid` is high.

## Structure
- Shared package `datamem_pkg`:
  - constants `DM_WIDTH` = 16 and `DM_AW` = 14;
  - requester-id typedef (`RQ_CPU` = 0, `RQ_DMA` = 1).
- Sub-module `rr_arb2`: 2-way round-robin grant logic plus the `last_gnt` flop, with inputs `req[1:0]` and output `gnt[1:0]` (one-hot or zero).
- Top level: the request mux, the read-tag pipeline flop and the two `rdata` hold registers.
- Instantiate `datamem` outside the arbiter. The bench connects both.

## Test plan
- After reset, rq0 writes 0xBEEF to 0x0010 alone, then reads 0x0010 → `rq0_ready` = 1 in both cycles; `rq0_rvalid` pulses 1 cycle after the read grant with `rq0_rdata` = 0xBEEF; `rq1_rvalid` stays 0.
- Both valid from the first cycle after reset: rq0 reads 0x0001, rq1 reads 0x0002, pre-loaded with 0x1111/0x2222 → grants alternate rq0, rq1, rq0…; each `rvalid` carries the matching word; each `rdata` is unchanged between its pulses.
- rq1 writes 0x3FFF ← 0xA5A5 while rq0 holds a read of 0x3FFF → rq1 is granted first after rq0's previous win; rq0's read returns 0xA5A5.
- Single requester streams 8 reads of 0x0000–0x0007 → one grant per cycle; 8 consecutive `rvalid` cycles with in-order data.
- `rst_n` asserted in the cycle right after a read grant → no `rvalid` after release; `rdata` = 0; `mem_we` = 0.
- rq0 drops `valid` while losing to rq1 → no rq0 access is issued; `last_gnt` = 1; the next lone rq0 request is granted immediately.

Source files
------------

// File: rtl/datamem_pkg.sv
`default_nettype none
// ============================================================================
// Package : datamem_pkg
// Brief   : Shared widths and requester ids for the datamem arbiter slice.
// Rev     : 1.0 - initial release
// ============================================================================
package datamem_pkg;

  localparam int DM_WIDTH = 16;
  localparam int DM_AW    = 14;

  typedef enum logic {
    RQ_CPU = 1'b0,
    RQ_DMA = 1'b1
  } rq_id_t;

endpackage
`default_nettype wire

// File: rtl/datamem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : datamem_arbiter_if
// Brief     : Two requester ports plus the datamem port of the arbiter.
// Rev       : 1.0 - initial release
// ============================================================================
interface datamem_arbiter_if import datamem_pkg::*; #(
  parameter int WIDTH = DM_WIDTH,
  parameter int AW    = DM_AW
);

  logic             rq0_valid;
  logic             rq0_we;
  logic [AW-1:0]    rq0_ad;
  logic [WIDTH-1:0] rq0_di;
  logic             rq0_ready;
  logic             rq0_rvalid;
  logic [WIDTH-1:0] rq0_rdata;

  logic             rq1_valid;
  logic             rq1_we;
  logic [AW-1:0]    rq1_ad;
  logic [WIDTH-1:0] rq1_di;
  logic             rq1_ready;
  logic             rq1_rvalid;
  logic [WIDTH-1:0] rq1_rdata;

  logic             mem_we;
  logic [AW-1:0]    mem_ad;
  logic [WIDTH-1:0] mem_di;
  logic [WIDTH-1:0] mem_dout;

  // Environment side: both requesters and the memory
  modport master (
    output rq0_valid, rq0_we, rq0_ad, rq0_di,
    input  rq0_ready, rq0_rvalid, rq0_rdata,
    output rq1_valid, rq1_we, rq1_ad, rq1_di,
    input  rq1_ready, rq1_rvalid, rq1_rdata,
    input  mem_we, mem_ad, mem_di,
    output mem_dout
  );

  modport slave (
    input  rq0_valid, rq0_we, rq0_ad, rq0_di,
    output rq0_ready, rq0_rvalid, rq0_rdata,
    input  rq1_valid, rq1_we, rq1_ad, rq1_di,
    output rq1_ready, rq1_rvalid, rq1_rdata,
    output mem_we, mem_ad, mem_di,
    input  mem_dout
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant with the last-winner pointer.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arb2 import datamem_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rq_id_t r_last_gnt;

  // A lone request is its own grant; contention goes to the previous loser
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (r_last_gnt == RQ_DMA) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= RQ_DMA;
    end else if (gnt[1]) begin
      r_last_gnt <= RQ_DMA;
    end else if (gnt[0]) begin
      r_last_gnt <= RQ_CPU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : datamem_arbiter
// Brief  : Shares single-ported datamem between CPU and DMA with tagged reads.
// Rev    : 1.0 - initial release
// ============================================================================
module datamem_arbiter import datamem_pkg::*; #(
  parameter int WIDTH = DM_WIDTH,
  parameter int AW    = DM_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  datamem_arbiter_if.slave   bus
);

  logic [1:0]       w_gnt;
  logic             w_we;
  logic [AW-1:0]    w_ad;
  logic [WIDTH-1:0] w_di;
  logic             w_rd_grant;
  rq_id_t           w_owner;
  logic             w_rvalid0;
  logic             w_rvalid1;

  logic             r_rd_pend;
  rq_id_t           r_rd_owner;
  logic [WIDTH-1:0] r_hold0;
  logic [WIDTH-1:0] r_hold1;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.rq1_valid, bus.rq0_valid}),
    .gnt   (w_gnt)
  );

  assign bus.rq0_ready = w_gnt[0];
  assign bus.rq1_ready = w_gnt[1];

  always_comb begin
    w_we = 1'b0;
    w_ad = '0;
    w_di = '0;
    if (w_gnt[0]) begin
      w_we = bus.rq0_we;
      w_ad = bus.rq0_ad;
      w_di = bus.rq0_di;
    end else if (w_gnt[1]) begin
      w_we = bus.rq1_we;
      w_ad = bus.rq1_ad;
      w_di = bus.rq1_di;
    end
  end

  assign bus.mem_we = w_we;
  assign bus.mem_ad = w_ad;
  assign bus.mem_di = w_di;

  assign w_rd_grant = (|w_gnt) && !w_we;
  assign w_owner    = rq_id_t'(w_gnt[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= RQ_CPU;
    end else begin
      r_rd_pend <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_owner <= w_owner;
      end
    end
  end

  assign w_rvalid0 = r_rd_pend && (r_rd_owner == RQ_CPU);
  assign w_rvalid1 = r_rd_pend && (r_rd_owner == RQ_DMA);

  // dout is only valid the cycle after a read grant, so capture it then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold0 <= '0;
      r_hold1 <= '0;
    end else begin
      if (w_rvalid0) r_hold0 <= bus.mem_dout;
      if (w_rvalid1) r_hold1 <= bus.mem_dout;
    end
  end

  assign bus.rq0_rvalid = w_rvalid0;
  assign bus.rq1_rvalid = w_rvalid1;
  assign bus.rq0_rdata  = w_rvalid0 ? bus.mem_dout : r_hold0;
  assign bus.rq1_rdata  = w_rvalid1 ? bus.mem_dout : r_hold1;

endmodule
`default_nettype wire

// File: tb/tb_datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_datamem_arbiter
// Brief  : Directed bench with a datamem model and a cycle-level reference.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_datamem_arbiter;
  import datamem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  datamem_arbiter_if bus ();

  datamem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] dmem      [0:16383];
  logic [15:0] model_mem [0:16383];

  function automatic logic [15:0] preload(input int a);
    return (a < 8) ? 16'(a * 'h1111) : 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // datamem: synchronous read, dout untouched by writes
  initial begin
    for (int i = 0; i < 16384; i++) dmem[i] <= preload(i);
    forever begin
      @(posedge clk);
      if (bus.mem_we) dmem[bus.mem_ad] <= bus.mem_di;
      else            bus.mem_dout     <= dmem[bus.mem_ad];
    end
  end

  // Reference: arbitration rules plus a list of outstanding reads with their data
  initial begin
    int          win;
    logic        m_last;
    logic        m_pend;
    int          m_owner;
    logic [15:0] m_data;
    logic [15:0] m_hold [2];
    logic        f_we [2];
    logic [13:0] f_ad [2];
    logic [15:0] f_di [2];
    logic        e_rv [2];
    logic [15:0] e_rd [2];
    for (int i = 0; i < 16384; i++) model_mem[i] = preload(i);
    m_last = 1'b1; m_pend = 1'b0; m_owner = 0; m_data = '0;
    m_hold[0] = '0; m_hold[1] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_last = 1'b1; m_pend = 1'b0;
        m_hold[0] = '0; m_hold[1] = '0;
        chk("m_rst_rvalid0", bus.rq0_rvalid, 0);
        chk("m_rst_rvalid1", bus.rq1_rvalid, 0);
        chk("m_rst_rdata0", bus.rq0_rdata, 0);
        chk("m_rst_rdata1", bus.rq1_rdata, 0);
      end else begin
        f_we[0] = bus.rq0_we; f_ad[0] = bus.rq0_ad; f_di[0] = bus.rq0_di;
        f_we[1] = bus.rq1_we; f_ad[1] = bus.rq1_ad; f_di[1] = bus.rq1_di;
        if (bus.rq0_valid && bus.rq1_valid) win = m_last ? 0 : 1;
        else if (bus.rq0_valid)             win = 0;
        else if (bus.rq1_valid)             win = 1;
        else                                win = -1;
        for (int n = 0; n < 2; n++) begin
          e_rv[n] = m_pend && (m_owner == n);
          e_rd[n] = e_rv[n] ? m_data : m_hold[n];
        end
        chk("m_ready0", bus.rq0_ready, win == 0);
        chk("m_ready1", bus.rq1_ready, win == 1);
        chk("m_mem_we", bus.mem_we, (win >= 0) ? f_we[win] : 1'b0);
        chk("m_mem_ad", bus.mem_ad, (win >= 0) ? f_ad[win] : 14'h0);
        chk("m_mem_di", bus.mem_di, (win >= 0) ? f_di[win] : 16'h0);
        chk("m_rvalid0", bus.rq0_rvalid, e_rv[0]);
        chk("m_rvalid1", bus.rq1_rvalid, e_rv[1]);
        chk("m_rdata0", bus.rq0_rdata, e_rd[0]);
        chk("m_rdata1", bus.rq1_rdata, e_rd[1]);
        if (m_pend) m_hold[m_owner] = m_data;
        m_pend = 1'b0;
        if (win >= 0) begin
          m_last = (win == 1);
          if (f_we[win]) begin
            model_mem[f_ad[win]] = f_di[win];
          end else begin
            m_pend  = 1'b1;
            m_owner = win;
            m_data  = model_mem[f_ad[win]];
          end
        end
      end
    end
  end

  task automatic drive(input logic v0, input logic we0, input logic [13:0] a0, input logic [15:0] d0,
                       input logic v1, input logic we1, input logic [13:0] a1, input logic [15:0] d1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rq0_valid = v0; bus.rq0_we = we0; bus.rq0_ad = a0; bus.rq0_di = d0;
    bus.rq1_valid = v1; bus.rq1_we = we1; bus.rq1_ad = a1; bus.rq1_di = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
  endtask

  task automatic rst_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.rq0_valid = 1'b0;
      bus.rq1_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rq0_valid = 1'b0; bus.rq0_we = 1'b0; bus.rq0_ad = '0; bus.rq0_di = '0;
    bus.rq1_valid = 1'b0; bus.rq1_we = 1'b0; bus.rq1_ad = '0; bus.rq1_di = '0;

    rst_cycles(2);
    chk("reset_rdata0", bus.rq0_rdata, 16'h0000);
    chk("reset_mem_we", bus.mem_we, 1'b0);

    // Lone write then read of 0x0010
    drive(1'b1, 1'b1, 14'h0010, 16'hBEEF, 1'b0, 1'b0, 14'h0, 16'h0);
    chk("t1_wr_ready0", bus.rq0_ready, 1'b1);
    chk("t1_wr_mem_we", bus.mem_we, 1'b1);
    drive(1'b1, 1'b0, 14'h0010, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    chk("t1_rd_ready0", bus.rq0_ready, 1'b1);
    idle();
    chk("t1_rvalid0", bus.rq0_rvalid, 1'b1);
    chk("t1_rdata0", bus.rq0_rdata, 16'hBEEF);
    chk("t1_rvalid1", bus.rq1_rvalid, 1'b0);
    idle();
    chk("t1_rvalid0_off", bus.rq0_rvalid, 1'b0);
    chk("t1_rdata0_hold", bus.rq0_rdata, 16'hBEEF);

    // Sustained contention straight out of reset
    rst_cycles(1);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 14'h0001, 16'h0, 1'b1, 1'b0, 14'h0002, 16'h0);
      chk("t2_ready0", bus.rq0_ready, (k % 2) == 0);
      chk("t2_ready1", bus.rq1_ready, (k % 2) == 1);
      if (k % 2 == 1) begin
        chk("t2_rvalid0", bus.rq0_rvalid, 1'b1);
        chk("t2_rdata0", bus.rq0_rdata, 16'h1111);
      end
      if (k % 2 == 0 && k > 0) begin
        chk("t2_rvalid1", bus.rq1_rvalid, 1'b1);
        chk("t2_rdata1", bus.rq1_rdata, 16'h2222);
        chk("t2_rdata0_hold", bus.rq0_rdata, 16'h1111);
      end
    end
    idle();

    // rq0 wins alone, then loses to rq1's write of the address it reads
    drive(1'b1, 1'b0, 14'h0003, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    chk("t3_lone_ready0", bus.rq0_ready, 1'b1);
    drive(1'b1, 1'b0, 14'h3FFF, 16'h0, 1'b1, 1'b1, 14'h3FFF, 16'hA5A5);
    chk("t3_ready1", bus.rq1_ready, 1'b1);
    chk("t3_ready0", bus.rq0_ready, 1'b0);
    chk("t3_mem_ad", bus.mem_ad, 14'h3FFF);
    chk("t3_mem_di", bus.mem_di, 16'hA5A5);
    chk("t3_rdata0_prev", bus.rq0_rdata, 16'h3333);
    drive(1'b1, 1'b0, 14'h3FFF, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    chk("t3_ready0_late", bus.rq0_ready, 1'b1);
    idle();
    chk("t3_rvalid0", bus.rq0_rvalid, 1'b1);
    chk("t3_rdata0", bus.rq0_rdata, 16'hA5A5);

    // Streamed reads from a single requester
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 1'b0, 14'(i), 16'h0);
      chk("t4_ready1", bus.rq1_ready, 1'b1);
      if (i > 0) begin
        chk("t4_rvalid1", bus.rq1_rvalid, 1'b1);
        chk("t4_rdata1", bus.rq1_rdata, preload(i - 1));
      end
    end
    idle();
    chk("t4_rdata1_last", bus.rq1_rdata, 16'h7777);
    idle();
    chk("t4_rvalid1_off", bus.rq1_rvalid, 1'b0);
    chk("t4_rdata1_hold", bus.rq1_rdata, 16'h7777);

    // Reset right after a read grant
    drive(1'b1, 1'b0, 14'h0010, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    chk("t5_ready0", bus.rq0_ready, 1'b1);
    rst_cycles(2);
    chk("t5_rst_rvalid0", bus.rq0_rvalid, 1'b0);
    idle();
    chk("t5_rvalid0", bus.rq0_rvalid, 1'b0);
    chk("t5_rdata0", bus.rq0_rdata, 16'h0000);
    chk("t5_rdata1", bus.rq1_rdata, 16'h0000);
    chk("t5_mem_we", bus.mem_we, 1'b0);

    // rq0 withdraws after losing to rq1
    drive(1'b1, 1'b0, 14'h0020, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    chk("t6_lone_ready0", bus.rq0_ready, 1'b1);
    drive(1'b1, 1'b0, 14'h0020, 16'h0, 1'b1, 1'b0, 14'h0005, 16'h0);
    chk("t6_ready0_lose", bus.rq0_ready, 1'b0);
    chk("t6_ready1_win", bus.rq1_ready, 1'b1);
    chk("t6_mem_ad", bus.mem_ad, 14'h0005);
    idle();
    chk("t6_no_access", bus.mem_ad, 14'h0000);
    chk("t6_rdata1", bus.rq1_rdata, 16'h5555);
    drive(1'b1, 1'b0, 14'h0010, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    chk("t6_ready0_next", bus.rq0_ready, 1'b1);
    drive(1'b1, 1'b0, 14'h0010, 16'h0, 1'b1, 1'b0, 14'h0006, 16'h0);
    chk("t6_rdata0", bus.rq0_rdata, 16'hBEEF);
    chk("t6_ready1_rr", bus.rq1_ready, 1'b1);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
